bcd_mul_seq: RTL and testbench
==============================

Name: bcd_mul_seq

Overview:
- Sequential BCD multiplier controller placed directly upstream of bcd_alu; it owns the ALU's operand and control inputs and consumes the ALU's results.
- It computes an unsigned NUM_DIGITS-digit product A*B using a shift-accumulate loop: per multiplier digit, one ALU SHL by 1 digit, then repeated ALU ADDs of the multiplicand.
- It is used by the RPN calculator's execution unit for the multiply key; the caller handles the product through a start/busy/done handshake.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in operands and result; must match the connected bcd_alu.
- SHIFT_AMT_WIDTH, $clog2(NUM_DIGITS+1), width of the ALU shift-amount port.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_num_a  input  NUM_DIGITS*4  multiplicand (BCD); captured on start.
- i_num_b  input  NUM_DIGITS*4  multiplier (BCD); captured on start.
- o_busy  output  1  high in the SHIFT and ADD states.
- o_done  output  1  one-cycle pulse when the result is ready.
- o_ovf  output  1  product exceeded NUM_DIGITS digits; valid with o_done and held afterwards.
- o_result  output  NUM_DIGITS*4  product; valid from o_done and held until the next accepted start.
- o_alu_op_code  output  `BCD_ALU_OP_CODE_WIDTH  ALU opcode.
- o_alu_shl_amt  output  SHIFT_AMT_WIDTH  constant 1.
- o_alu_shr_amt  output  SHIFT_AMT_WIDTH  constant 0.
- o_alu_shl_digit, o_alu_shr_digit  output  4  constant 0.
- o_alu_add_cin  output  1  constant 0.
- o_alu_num_a  output  NUM_DIGITS*4  accumulator register.
- o_alu_num_b  output  NUM_DIGITS*4  multiplicand register.
- i_alu_num  input  NUM_DIGITS*4  ALU result.
- i_alu_shl_digit  input  4  digit shifted out by the ALU SHL.
- i_alu_add_cout  input  1  ALU add carry-out.

Behaviour:
- Clocking and reset: one clock (i_clk); reset (i_rst) is asynchronous and active-high.
- Reset values: state=IDLE; acc, mcand, mplier, digit counter, add counter, o_result = 0; o_busy=0, o_done=0, o_ovf=0.
- ALU outputs are combinational from state:
  - o_alu_op_code = `BCD_ALU_OP_SHL in SHIFT, `BCD_ALU_OP_ADD in all other states.
  - o_alu_num_a = acc and o_alu_num_b = mcand at all times.
- The ALU is combinational; its result is registered at the same edge.
- States:
  - IDLE: when i_start=1 at an edge: acc<=0, mcand<=i_num_a, mplier<=i_num_b, dcnt<=NUM_DIGITS, o_ovf<=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT:
    - acc<=i_alu_num (acc*10).
    - cur<=top digit of mplier; mplier<=mplier<<4; dcnt<=dcnt-1.
    - If i_alu_shl_digit!=0: overflow abort.
    - Else if top digit!=0: go to ADD.
    - Else if dcnt==1: go to DONE.
    - Else: stay in SHIFT.
  - ADD:
    - acc<=i_alu_num; cur<=cur-1.
    - If i_alu_add_cout=1: overflow abort.
    - Else if cur==1 and dcnt==0: go to DONE.
    - Else if cur==1: go to SHIFT.
    - Else: stay in ADD.
  - Overflow abort: o_ovf<=1, acc<=0, go to DONE.
  - DONE: o_done=1 for exactly one cycle; o_result<=acc at entry (registered so it is valid during DONE); next state is IDLE unconditionally.
- Latency: the first SHIFT cycle follows the start edge. Busy cycles = NUM_DIGITS + (sum of the multiplier's digits) when there is no overflow. o_done rises on the next cycle after that.
- Overflow termination is early: the abort happens in the cycle where the overflow is detected, and o_result=0 in that case.
- i_start is ignored while busy and in DONE; there is no queueing.
- Operands are sampled only at the start edge; input changes during busy have no effect.
- Multiplier of 0: NUM_DIGITS SHIFT cycles, result 0, no overflow.
- Non-BCD input digits are outside the contract; behaviour is undefined but must not lock the FSM. Each state must still exit within 9*NUM_DIGITS+NUM_DIGITS cycles.
- i_rst asserted mid-operation: immediate return to IDLE with the reset values; no o_done is produced for the aborted operation.

Test Plan:
- NUM_DIGITS=4, a=0012, b=0003, start pulse -> o_busy high 7 cycles (4 SHIFT + 3 ADD), then o_done pulse, o_result=0036, o_ovf=0.
- a=0123, b=0000 -> 4 busy cycles, o_result=0000, o_ovf=0; then a=9999, b=0001 -> o_result=9999, 5 busy cycles.
- Add overflow: a=5000, b=0002 -> abort on the 2nd ADD (busy 6 cycles), o_done, o_ovf=1, o_result=0000.
- Shift overflow: a=0100, b=0110 -> abort on the 4th SHIFT with i_alu_shl_digit=1, o_ovf=1, o_result=0000.
- With the real bcd_alu attached: i_start re-pulsed and operands changed mid-run are ignored; after o_done, the next start with a=0025, b=0004 gives 0100. Also check that o_result holds its previous value until the new done.
- i_rst asserted on the 3rd busy cycle of 0012*0003 -> outputs immediately take reset values, no o_done follows, and a subsequent start completes normally.

Source files
------------

// File: rtl/bcd_mul_seq_if.sv
// Caller handshake and bcd_alu operand/result bus of the sequential BCD multiplier.
// The multiplier attaches through the slave modport; caller plus ALU sit on the master side.
`ifndef BCD_ALU_OP_CODE_WIDTH
`define BCD_ALU_OP_CODE_WIDTH 2
`define BCD_ALU_OP_ADD 2'd0
`define BCD_ALU_OP_SUB 2'd1
`define BCD_ALU_OP_SHL 2'd2
`define BCD_ALU_OP_SHR 2'd3
`endif

interface bcd_mul_seq_if #(
   parameter int NUM_DIGITS      = 4,
   parameter int SHIFT_AMT_WIDTH = $clog2(NUM_DIGITS + 1)
);
   logic                              i_start;
   logic [NUM_DIGITS*4-1:0]           i_num_a;
   logic [NUM_DIGITS*4-1:0]           i_num_b;
   logic                              o_busy;
   logic                              o_done;
   logic                              o_ovf;
   logic [NUM_DIGITS*4-1:0]           o_result;
   logic [`BCD_ALU_OP_CODE_WIDTH-1:0] o_alu_op_code;
   logic [SHIFT_AMT_WIDTH-1:0]        o_alu_shl_amt;
   logic [SHIFT_AMT_WIDTH-1:0]        o_alu_shr_amt;
   logic [3:0]                        o_alu_shl_digit;
   logic [3:0]                        o_alu_shr_digit;
   logic                              o_alu_add_cin;
   logic [NUM_DIGITS*4-1:0]           o_alu_num_a;
   logic [NUM_DIGITS*4-1:0]           o_alu_num_b;
   logic [NUM_DIGITS*4-1:0]           i_alu_num;
   logic [3:0]                        i_alu_shl_digit;
   logic                              i_alu_add_cout;

   modport slave (
      input  i_start, i_num_a, i_num_b, i_alu_num, i_alu_shl_digit, i_alu_add_cout,
      output o_busy, o_done, o_ovf, o_result, o_alu_op_code, o_alu_shl_amt,
             o_alu_shr_amt, o_alu_shl_digit, o_alu_shr_digit, o_alu_add_cin,
             o_alu_num_a, o_alu_num_b
   );

   modport master (
      output i_start, i_num_a, i_num_b, i_alu_num, i_alu_shl_digit, i_alu_add_cout,
      input  o_busy, o_done, o_ovf, o_result, o_alu_op_code, o_alu_shl_amt,
             o_alu_shr_amt, o_alu_shl_digit, o_alu_shr_digit, o_alu_add_cin,
             o_alu_num_a, o_alu_num_b
   );
endinterface

// File: rtl/bcd_mul_seq.sv
// Sequential BCD multiplier: per multiplier digit one ALU shift-left of the accumulator,
// then one ALU add of the multiplicand per unit of that digit; aborts early on overflow.
`ifndef BCD_ALU_OP_CODE_WIDTH
`define BCD_ALU_OP_CODE_WIDTH 2
`define BCD_ALU_OP_ADD 2'd0
`define BCD_ALU_OP_SUB 2'd1
`define BCD_ALU_OP_SHL 2'd2
`define BCD_ALU_OP_SHR 2'd3
`endif

module bcd_mul_seq #(
   parameter int NUM_DIGITS      = 4,
   parameter int SHIFT_AMT_WIDTH = $clog2(NUM_DIGITS + 1)
) (
   input logic         i_clk,
   input logic         i_rst,
   bcd_mul_seq_if.slave bus
);
   localparam int W     = NUM_DIGITS * 4;
   localparam int CNT_W = $clog2(NUM_DIGITS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ADD   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [W-1:0]     acc;
   logic [W-1:0]     mcand;
   logic [W-1:0]     mplier;
   logic [CNT_W-1:0] dcnt;
   logic [3:0]       cur;
   logic [W-1:0]     result_q;
   logic             busy_q;
   logic             done_q;
   logic             ovf_q;

   function automatic logic [3:0] top_digit(input logic [W-1:0] v);
      return v[W-1 -: 4];
   endfunction

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         dcnt     <= '0;
         cur      <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.i_start) begin
                  acc    <= '0;
                  mcand  <= bus.i_num_a;
                  mplier <= bus.i_num_b;
                  dcnt   <= CNT_W'(NUM_DIGITS);
                  ovf_q  <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               acc    <= bus.i_alu_num;
               cur    <= top_digit(mplier);
               mplier <= mplier << 4;
               dcnt   <= dcnt - CNT_W'(1);
               // A non-zero digit leaving the top means the product no longer fits.
               if (bus.i_alu_shl_digit != 4'd0) begin
                  ovf_q    <= 1'b1;
                  acc      <= '0;
                  result_q <= '0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end else if (top_digit(mplier) != 4'd0) begin
                  state <= ADD;
               end else if (dcnt == CNT_W'(1)) begin
                  result_q <= bus.i_alu_num;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end
            end
            ADD: begin
               acc <= bus.i_alu_num;
               cur <= cur - 4'd1;
               if (bus.i_alu_add_cout) begin
                  ovf_q    <= 1'b1;
                  acc      <= '0;
                  result_q <= '0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end else if (cur == 4'd1) begin
                  if (dcnt == '0) begin
                     result_q <= bus.i_alu_num;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state    <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_alu_op_code   = (state == SHIFT) ? `BCD_ALU_OP_SHL : `BCD_ALU_OP_ADD;
   assign bus.o_alu_num_a     = acc;
   assign bus.o_alu_num_b     = mcand;
   assign bus.o_alu_shl_amt   = SHIFT_AMT_WIDTH'(1);
   assign bus.o_alu_shr_amt   = '0;
   assign bus.o_alu_shl_digit = 4'd0;
   assign bus.o_alu_shr_digit = 4'd0;
   assign bus.o_alu_add_cin   = 1'b0;
   assign bus.o_busy          = busy_q;
   assign bus.o_done          = done_q;
   assign bus.o_ovf           = ovf_q;
   assign bus.o_result        = result_q;
endmodule

// File: tb/tb_bcd_mul_seq.sv
// Bench for bcd_mul_seq with a behavioural 4-digit bcd_alu attached; directed products are
// queued with hand-computed results and checked by a monitor whenever o_done pulses.
`ifndef BCD_ALU_OP_CODE_WIDTH
`define BCD_ALU_OP_CODE_WIDTH 2
`define BCD_ALU_OP_ADD 2'd0
`define BCD_ALU_OP_SUB 2'd1
`define BCD_ALU_OP_SHL 2'd2
`define BCD_ALU_OP_SHR 2'd3
`endif

module tb_bcd_mul_seq;
   logic clk;
   logic rst;

   bcd_mul_seq_if #(.NUM_DIGITS(4)) bus ();

   bcd_mul_seq #(.NUM_DIGITS(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] res;
      logic        ovf;
      int          busy;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          busy_cnt = 0;
   logic [15:0] last_res = 16'h0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b, input logic cin);
      logic [15:0] s;
      logic        c;
      logic [4:0]  d;
      s = '0;
      c = cin;
      for (int k = 0; k < 4; k++) begin
         d = 5'(a[k*4 +: 4]) + 5'(b[k*4 +: 4]) + 5'(c);
         if (d > 5'd9) begin
            d = d - 5'd10;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         s[k*4 +: 4] = d[3:0];
      end
      return {c, s};
   endfunction

   always_comb begin
      logic [16:0] sum;
      bus.i_alu_num       = '0;
      bus.i_alu_shl_digit = 4'd0;
      bus.i_alu_add_cout  = 1'b0;
      sum = bcd_add(bus.o_alu_num_a, bus.o_alu_num_b, bus.o_alu_add_cin);
      case (bus.o_alu_op_code)
         `BCD_ALU_OP_SHL: begin
            bus.i_alu_num       = {bus.o_alu_num_a[11:0], bus.o_alu_shl_digit};
            bus.i_alu_shl_digit = bus.o_alu_num_a[15:12];
         end
         `BCD_ALU_OP_ADD: begin
            bus.i_alu_num      = sum[15:0];
            bus.i_alu_add_cout = sum[16];
         end
         default: bus.i_alu_num = bus.o_alu_num_a;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: counts busy cycles and scores each done pulse against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_cnt = 0;
         last_res = 16'h0000;
      end else begin
         if (bus.o_busy) begin
            busy_cnt++;
            check("result_hold", 32'(bus.o_result), 32'(last_res));
         end
         if (bus.o_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got o_done=1 expected no done, result %0h", bus.o_result);
            end else begin
               e = exp_q.pop_front();
               check("result", 32'(bus.o_result), 32'(e.res));
               check("ovf", 32'(bus.o_ovf), 32'(e.ovf));
               check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
               last_res = e.res;
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input bit push,
                           input logic [15:0] res, input logic ovf, input int busy);
      exp_t e;
      @(posedge clk);
      #1;
      bus.i_start = 1'b1;
      bus.i_num_a = a;
      bus.i_num_b = b;
      if (push) begin
         e.res = res;
         e.ovf = ovf;
         e.busy = busy;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.i_start = 1'b0;
      bus.i_num_a = 16'h0000;
      bus.i_num_b = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.o_busy), 32'd0);
      check("rst_done", 32'(bus.o_done), 32'd0);
      check("rst_ovf", 32'(bus.o_ovf), 32'd0);
      check("rst_result", 32'(bus.o_result), 32'h0);
      check("rst_acc", 32'(bus.o_alu_num_a), 32'h0);
      check("rst_op", 32'(bus.o_alu_op_code), 32'(`BCD_ALU_OP_ADD));
      check("shl_amt", 32'(bus.o_alu_shl_amt), 32'd1);
      check("shr_amt", 32'(bus.o_alu_shr_amt), 32'd0);
      check("shl_digit", 32'(bus.o_alu_shl_digit), 32'd0);
      check("shr_digit", 32'(bus.o_alu_shr_digit), 32'd0);
      check("add_cin", 32'(bus.o_alu_add_cin), 32'd0);
      rst = 1'b0;

      start_op(16'h0012, 16'h0003, 1'b1, 16'h0036, 1'b0, 7);
      wait_drain();
      start_op(16'h0123, 16'h0000, 1'b1, 16'h0000, 1'b0, 4);
      wait_drain();
      start_op(16'h9999, 16'h0001, 1'b1, 16'h9999, 1'b0, 5);
      wait_drain();
      start_op(16'h5000, 16'h0002, 1'b1, 16'h0000, 1'b1, 6);
      wait_drain();
      check("ovf_held", 32'(bus.o_ovf), 32'd1);
      start_op(16'h0100, 16'h0110, 1'b1, 16'h0000, 1'b1, 6);
      wait_drain();
      start_op(16'h0099, 16'h0099, 1'b1, 16'h9801, 1'b0, 22);
      wait_drain();

      // Re-pulsed start and changed operands mid-run must not disturb the product.
      start_op(16'h0012, 16'h0003, 1'b1, 16'h0036, 1'b0, 7);
      @(posedge clk);
      #1;
      bus.i_start = 1'b1;
      bus.i_num_a = 16'h9999;
      bus.i_num_b = 16'h9999;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      wait_drain();
      start_op(16'h0025, 16'h0004, 1'b1, 16'h0100, 1'b0, 8);
      wait_drain();

      // Reset during the third busy cycle: no done may follow.
      start_op(16'h0012, 16'h0003, 1'b0, 16'h0000, 1'b0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("pre_rst_busy", 32'(bus.o_busy), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(bus.o_busy), 32'd0);
      check("midrst_done", 32'(bus.o_done), 32'd0);
      check("midrst_result", 32'(bus.o_result), 32'h0);
      check("midrst_acc", 32'(bus.o_alu_num_a), 32'h0);
      check("midrst_mcand", 32'(bus.o_alu_num_b), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (15) @(posedge clk);
      check("idle_after_rst", 32'(bus.o_busy), 32'd0);
      start_op(16'h0012, 16'h0003, 1'b1, 16'h0036, 1'b0, 7);
      wait_drain();
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
